// File: rtl/arf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arf_pkg
//  Description : Shared constants for the address register file: the
//                function codes applied by each register, the read-port
//                select codes and the bit positions of the per-register
//                enables inside RegSel.
//  Optional    : ARF_SATURATE_EN (used by arf_register16) switches
//                increment/decrement from wrapping to saturating.
//  Revision    : 1.0 - initial release
// ============================================================================
package arf_pkg;

    // Operation applied by every enabled register on a rising edge
    localparam logic [1:0] FUN_DEC  = 2'b00;
    localparam logic [1:0] FUN_INC  = 2'b01;
    localparam logic [1:0] FUN_LOAD = 2'b10;
    localparam logic [1:0] FUN_CLR  = 2'b11;

    // Read-port source selects; both low codes map to PC
    localparam logic [1:0] SEL_PC0  = 2'b00;
    localparam logic [1:0] SEL_PC1  = 2'b01;
    localparam logic [1:0] SEL_SP   = 2'b10;
    localparam logic [1:0] SEL_AR   = 2'b11;

    // Bit positions within RegSel
    localparam int unsigned C_RSEL_PC = 2;
    localparam int unsigned C_RSEL_AR = 1;
    localparam int unsigned C_RSEL_SP = 0;

endpackage : arf_pkg
`default_nettype wire

// File: rtl/address_register_file_if.sv
`default_nettype none
// ============================================================================
//  Module      : address_register_file_if
//  Description : Bus bundle for the address register file.
//  Signals     : I        - load data
//                RegSel   - per-register enables {PC, AR, SP}
//                FunSel   - operation applied to enabled registers
//                OutCSel  - OutC source select
//                OutDSel  - OutD source select
//                OutC     - selected register value (port C)
//                OutD     - selected register value (port D)
//  Modports    : master - drives controls/data, observes outputs
//                slave  - the register file itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface address_register_file_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] I;
    logic [2:0]       RegSel;
    logic [1:0]       FunSel;
    logic [1:0]       OutCSel;
    logic [1:0]       OutDSel;
    logic [WIDTH-1:0] OutC;
    logic [WIDTH-1:0] OutD;

    modport master (
        output I, RegSel, FunSel, OutCSel, OutDSel,
        input  OutC, OutD
    );

    modport slave (
        input  I, RegSel, FunSel, OutCSel, OutDSel,
        output OutC, OutD
    );

endinterface : address_register_file_if
`default_nettype wire

// File: rtl/arf_register16.sv
`default_nettype none
// ============================================================================
//  Module      : arf_register16
//  Description : One address register. When enabled on a rising Clock edge
//                it decrements, increments, loads I or clears, as chosen by
//                FunSel; otherwise it holds. Asynchronous active-low Reset
//                clears the state.
//  Ports       : Clock  - rising-edge clock
//                Reset  - asynchronous, active-low clear
//                E      - enable
//                FunSel - operation code
//                I      - load data
//                Q      - register contents (the state flop itself)
//  Optional    : ARF_SATURATE_EN defined -> increment stops at all-ones and
//                decrement stops at zero; undefined -> both wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module arf_register16
    import arf_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic             Clock,
    input  wire logic             Reset,
    input  wire logic             E,
    input  wire logic [1:0]       FunSel,
    input  wire logic [WIDTH-1:0] I,
    output logic      [WIDTH-1:0] Q
);

    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONES = '1;
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = Q;
        if (E) begin
            case (FunSel)
                FUN_DEC: begin
`ifdef ARF_SATURATE_EN
                    q_d = (Q == C_ZERO) ? Q : (Q - C_ONE);
`else
                    q_d = Q - C_ONE;
`endif
                end
                FUN_INC: begin
`ifdef ARF_SATURATE_EN
                    q_d = (Q == C_ONES) ? Q : (Q + C_ONE);
`else
                    q_d = Q + C_ONE;
`endif
                end
                FUN_LOAD: q_d = I;
                FUN_CLR:  q_d = C_ZERO;
                default:  q_d = Q;
            endcase
        end
    end

    // Q is the flop itself (no _q suffix) so PC.Q / AR.Q / SP.Q are the
    // state elements seen from the hierarchy.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Q <= C_ZERO;
        end else begin
            Q <= q_d;
        end
    end

endmodule : arf_register16
`default_nettype wire

// File: rtl/address_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : address_register_file
//  Description : Three address registers (PC, AR, SP) sharing one function
//                code, each gated by its own RegSel bit, with two
//                independent combinational read ports OutC and OutD.
//  Ports       : Clock - rising-edge clock
//                Reset - asynchronous, active-low clear of all registers
//                bus   - address_register_file_if.slave
//                        (I, RegSel, FunSel, OutCSel, OutDSel -> OutC, OutD)
//  Read select : 00/01 -> PC, 10 -> SP, 11 -> AR
//  Optional    : ARF_SATURATE_EN (see arf_register16) selects saturating
//                increment/decrement instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module address_register_file
    import arf_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic              Clock,
    input  wire logic              Reset,
    address_register_file_if.slave bus
);

    logic [WIDTH-1:0] w_pc;
    logic [WIDTH-1:0] w_ar;
    logic [WIDTH-1:0] w_sp;
    logic [WIDTH-1:0] w_out_c;
    logic [WIDTH-1:0] w_out_d;

    arf_register16 #(.WIDTH(WIDTH)) PC (
        .Clock  (Clock),
        .Reset  (Reset),
        .E      (bus.RegSel[C_RSEL_PC]),
        .FunSel (bus.FunSel),
        .I      (bus.I),
        .Q      (w_pc)
    );

    arf_register16 #(.WIDTH(WIDTH)) AR (
        .Clock  (Clock),
        .Reset  (Reset),
        .E      (bus.RegSel[C_RSEL_AR]),
        .FunSel (bus.FunSel),
        .I      (bus.I),
        .Q      (w_ar)
    );

    arf_register16 #(.WIDTH(WIDTH)) SP (
        .Clock  (Clock),
        .Reset  (Reset),
        .E      (bus.RegSel[C_RSEL_SP]),
        .FunSel (bus.FunSel),
        .I      (bus.I),
        .Q      (w_sp)
    );

    // Read ports are pure muxes on the register outputs: a write is visible
    // right after the edge that performs it, and reset zeros show at once.
    always_comb begin
        w_out_c = w_pc;
        case (bus.OutCSel)
            SEL_PC0, SEL_PC1: w_out_c = w_pc;
            SEL_SP:           w_out_c = w_sp;
            SEL_AR:           w_out_c = w_ar;
            default:          w_out_c = w_pc;
        endcase
    end

    always_comb begin
        w_out_d = w_pc;
        case (bus.OutDSel)
            SEL_PC0, SEL_PC1: w_out_d = w_pc;
            SEL_SP:           w_out_d = w_sp;
            SEL_AR:           w_out_d = w_ar;
            default:          w_out_d = w_pc;
        endcase
    end

    assign bus.OutC = w_out_c;
    assign bus.OutD = w_out_d;

endmodule : address_register_file
`default_nettype wire

// File: tb/tb_address_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_address_register_file
//  Description : Self-checking bench for address_register_file. A reference
//                model of PC/AR/SP is kept as plain integers; directed
//                scenarios and a randomized run compare both read ports
//                against it. Honours ARF_SATURATE_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_address_register_file;

    logic Clock;
    logic Reset;

    int n_checks;
    int n_pass;

    // Reference register contents
    logic [15:0] m_pc;
    logic [15:0] m_ar;
    logic [15:0] m_sp;

    address_register_file_if #(.WIDTH(16)) bus ();

    address_register_file #(.WIDTH(16)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Next value of one register under a function code, from integer math
    function automatic logic [15:0] m_apply(input logic [15:0] v, input logic [1:0] f,
                                            input logic [15:0] d);
        int t;
        t = int'(v);
        case (f)
            2'b00: begin
                t = t - 1;
`ifdef ARF_SATURATE_EN
                if (t < 0) t = 0;
`else
                if (t < 0) t = t + 65536;
`endif
            end
            2'b01: begin
                t = t + 1;
`ifdef ARF_SATURATE_EN
                if (t > 65535) t = 65535;
`else
                if (t > 65535) t = t - 65536;
`endif
            end
            2'b10: t = int'(d);
            default: t = 0;
        endcase
        return t[15:0];
    endfunction

    function automatic logic [15:0] m_read(input logic [1:0] sel);
        if (sel == 2'b10) return m_sp;
        if (sel == 2'b11) return m_ar;
        return m_pc;
    endfunction

    // One clocked operation: inputs applied at the falling edge, model
    // updated at the rising edge, bench resumes 1 ns after it.
    task automatic do_op(input logic [2:0] rs, input logic [1:0] fs, input logic [15:0] d);
        @(negedge Clock);
        bus.RegSel = rs;
        bus.FunSel = fs;
        bus.I      = d;
        @(posedge Clock);
        if (rs[2]) m_pc = m_apply(m_pc, fs, d);
        if (rs[1]) m_ar = m_apply(m_ar, fs, d);
        if (rs[0]) m_sp = m_apply(m_sp, fs, d);
        #1;
        bus.RegSel = 3'b000;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        bus.RegSel = 3'b000; bus.FunSel = 2'b00; bus.I = 16'h0000;
        bus.OutCSel = 2'b00; bus.OutDSel = 2'b11;
        #2 Reset = 1'b0;
        m_pc = 16'h0; m_ar = 16'h0; m_sp = 16'h0;
        for (int s = 0; s < 4; s++) begin
            bus.OutCSel = s[1:0];
            bus.OutDSel = 2'(3 - s);
            #1;
            n_checks++;
            if (bus.OutC !== 16'h0000)
                $display("FAIL reset_outc sel=%0d got=%h exp=0000", s, bus.OutC);
            else n_pass++;
            n_checks++;
            if (bus.OutD !== 16'h0000)
                $display("FAIL reset_outd sel=%0d got=%h exp=0000", 3 - s, bus.OutD);
            else n_pass++;
        end
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic test_preload;
        do_op(3'b100, 2'b10, 16'h1234);
        do_op(3'b001, 2'b10, 16'h3456);
        do_op(3'b010, 2'b10, 16'h5678);
        bus.RegSel = 3'b000;
        bus.OutCSel = 2'b00;
        bus.OutDSel = 2'b11;
        #5;
        n_checks++;
        if (bus.OutC !== 16'h1234) $display("FAIL preload_outc got=%h exp=1234", bus.OutC);
        else n_pass++;
        n_checks++;
        if (bus.OutD !== 16'h5678) $display("FAIL preload_outd got=%h exp=5678", bus.OutD);
        else n_pass++;
    endtask

    task automatic test_load_multi;
        do_op(3'b111, 2'b10, 16'h1234);
        do_op(3'b110, 2'b10, 16'h3548);
        bus.OutCSel = 2'b10;
        bus.OutDSel = 2'b00;
        #1;
        n_checks++;
        if (bus.OutC !== 16'h1234) $display("FAIL load_sp_held got=%h exp=1234", bus.OutC);
        else n_pass++;
        n_checks++;
        if (bus.OutD !== 16'h3548) $display("FAIL load_pc got=%h exp=3548", bus.OutD);
        else n_pass++;
        bus.OutDSel = 2'b11;
        #1;
        n_checks++;
        if (bus.OutD !== 16'h3548) $display("FAIL load_ar got=%h exp=3548", bus.OutD);
        else n_pass++;
    endtask

    task automatic test_wrap;
        logic [15:0] exp_pc;
        logic [15:0] exp_sp;
`ifdef ARF_SATURATE_EN
        exp_pc = 16'hFFFF; exp_sp = 16'h0000;
`else
        exp_pc = 16'h0000; exp_sp = 16'hFFFF;
`endif
        do_op(3'b100, 2'b10, 16'hFFFF);
        do_op(3'b001, 2'b11, 16'h0000);
        do_op(3'b100, 2'b01, 16'h0000);
        do_op(3'b001, 2'b00, 16'h0000);
        bus.OutCSel = 2'b01;
        bus.OutDSel = 2'b10;
        #1;
        n_checks++;
        if (bus.OutC !== exp_pc) $display("FAIL wrap_pc_inc got=%h exp=%h", bus.OutC, exp_pc);
        else n_pass++;
        n_checks++;
        if (bus.OutD !== exp_sp) $display("FAIL wrap_sp_dec got=%h exp=%h", bus.OutD, exp_sp);
        else n_pass++;
    endtask

    task automatic test_clear;
        do_op(3'b111, 2'b10, 16'h9E37);
        do_op(3'b111, 2'b11, 16'hFFFF);
        for (int s = 0; s < 4; s++) begin
            bus.OutCSel = s[1:0];
            bus.OutDSel = s[1:0];
            #1;
            n_checks++;
            if (bus.OutC !== 16'h0000 || bus.OutD !== 16'h0000)
                $display("FAIL clear_all sel=%0d got=%h/%h exp=0000", s, bus.OutC, bus.OutD);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset;
        do_op(3'b111, 2'b10, 16'hABCD);
        bus.OutCSel = 2'b00;
        bus.OutDSel = 2'b11;
        @(posedge Clock);
        #2;
        Reset = 1'b0;
        m_pc = 16'h0; m_ar = 16'h0; m_sp = 16'h0;
        #1;
        n_checks++;
        if (bus.OutC !== 16'h0000 || bus.OutD !== 16'h0000)
            $display("FAIL async_reset got=%h/%h exp=0000", bus.OutC, bus.OutD);
        else n_pass++;
        @(negedge Clock);
        Reset = 1'b1;
        do_op(3'b010, 2'b01, 16'h0000);
        bus.OutCSel = 2'b11;
        bus.OutDSel = 2'b10;
        #1;
        n_checks++;
        if (bus.OutC !== 16'h0001) $display("FAIL post_reset_ar got=%h exp=0001", bus.OutC);
        else n_pass++;
        n_checks++;
        if (bus.OutD !== 16'h0000) $display("FAIL post_reset_sp got=%h exp=0000", bus.OutD);
        else n_pass++;
        bus.OutDSel = 2'b00;
        #1;
        n_checks++;
        if (bus.OutD !== 16'h0000) $display("FAIL post_reset_pc got=%h exp=0000", bus.OutD);
        else n_pass++;
    endtask

    task automatic test_select_alias;
        do_op(3'b100, 2'b10, 16'h55AA);
        bus.OutCSel = 2'b01;
        bus.OutDSel = 2'b00;
        #1;
        n_checks++;
        if (bus.OutC !== 16'h55AA || bus.OutD !== 16'h55AA)
            $display("FAIL pc_alias got=%h/%h exp=55aa", bus.OutC, bus.OutD);
        else n_pass++;
    endtask

    // Random operations: before each edge the ports must still show the old
    // contents, after it the new ones.
    task automatic test_random;
        logic [2:0]  rs;
        logic [1:0]  fs;
        logic [15:0] d;
        logic [1:0]  cs;
        logic [1:0]  ds;
        for (int n = 0; n < 200; n++) begin
            rs = 3'($urandom_range(0, 7));
            fs = 2'($urandom_range(0, 3));
            d  = 16'($urandom);
            if (n % 16 == 0) d = 16'hFFFF;
            if (n % 16 == 8) d = 16'h0000;
            cs = 2'($urandom_range(0, 3));
            ds = 2'($urandom_range(0, 3));
            @(negedge Clock);
            bus.RegSel = rs; bus.FunSel = fs; bus.I = d;
            bus.OutCSel = cs; bus.OutDSel = ds;
            #1;
            n_checks++;
            if (bus.OutC !== m_read(cs) || bus.OutD !== m_read(ds))
                $display("FAIL rand_pre n=%0d got=%h/%h exp=%h/%h", n, bus.OutC, bus.OutD,
                         m_read(cs), m_read(ds));
            else n_pass++;
            @(posedge Clock);
            if (rs[2]) m_pc = m_apply(m_pc, fs, d);
            if (rs[1]) m_ar = m_apply(m_ar, fs, d);
            if (rs[0]) m_sp = m_apply(m_sp, fs, d);
            #1;
            n_checks++;
            if (bus.OutC !== m_read(cs) || bus.OutD !== m_read(ds))
                $display("FAIL rand_post n=%0d rs=%b fs=%b got=%h/%h exp=%h/%h", n, rs, fs,
                         bus.OutC, bus.OutD, m_read(cs), m_read(ds));
            else n_pass++;
        end
        bus.RegSel = 3'b000;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_preload();
        test_load_multi();
        test_wrap();
        test_clear();
        test_async_reset();
        test_select_alias();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_address_register_file
`default_nettype wire

// File: doc/address_register_file.md
Name: address_register_file

Overview:
- Three 16-bit address registers for the datapath: PC (program counter), AR (address register) and SP (stack pointer).
- Each register is written by a shared 2-bit function code and gated by its own enable bit.
- Two independent combinational read ports, OutC and OutD, feed the memory address path and the ALU/bus muxes.

Parameters:
- WIDTH, 16, register and data width.

Ports:
- Clock  input  1  system clock; all register updates on the rising edge.
- Reset  input  1  asynchronous, active-low; clears PC, AR and SP to 0.
- I  input  WIDTH  load data.
- RegSel  input  3  per-register enable: bit2 = PC, bit1 = AR, bit0 = SP (1 = enabled).
- FunSel  input  2  operation applied to every enabled register.
- OutCSel  input  2  OutC source select.
- OutDSel  input  2  OutD source select.
- OutC  output  WIDTH  selected register value.
- OutD  output  WIDTH  selected register value.

Behaviour:
- Registers are instances named PC, AR and SP of a 16-bit register sub-module that holds its state in a register named Q. The hierarchical paths PC.Q, AR.Q and SP.Q must exist and be forceable.
- Reset low, at any time, asynchronously sets every Q to 16'h0000. This takes priority over the clock.
- While Reset is low, OutC and OutD follow the cleared registers (0x0000).
- On a rising Clock edge with Reset high, each register whose RegSel bit is 1 applies FunSel:
  - 00: decrement, Q-1, wraps 0x0000 -> 0xFFFF.
  - 01: increment, Q+1, wraps 0xFFFF -> 0x0000.
  - 10: load, Q = I[WIDTH-1:0].
  - 11: clear, Q = 0.
- A register whose RegSel bit is 0 holds its value.
- RegSel = 000: no register changes.
- Several enable bits set: all enabled registers perform the same FunSel in the same cycle.
- Read muxes are purely combinational, with zero-cycle latency from register or select changes:
  - Select 00 -> PC.
  - Select 01 -> PC.
  - Select 10 -> SP.
  - Select 11 -> AR.
- OutC and OutD are independent and may select the same register.
- Read-during-write: outputs show the old value until the clock edge, then the new value in the same cycle after the edge.
- No handshake; no X propagation for legal select codes.

Optional Feature:
- Macro ARF_SATURATE_EN.
- Defined: increment saturates at 0xFFFF and decrement saturates at 0x0000.
- Undefined (default): both wrap modulo 2^16 as above.
- Load and clear are unaffected either way.

Decomposition:
- Shared package arf_pkg holds:
  - FunSel constants FUN_DEC = 2'b00, FUN_INC = 2'b01, FUN_LOAD = 2'b10, FUN_CLR = 2'b11.
  - Select constants SEL_PC0 = 2'b00, SEL_PC1 = 2'b01, SEL_SP = 2'b10, SEL_AR = 2'b11.
  - RegSel bit indices.
- One natural sub-module, arf_register16: Clock, Reset, E (enable), FunSel, I, Q.
  - Instantiated three times as PC, AR and SP.
  - The two read muxes live in the top module.

Test Plan:
- Preload PC = 1234, SP = 3456, AR = 5678 with RegSel = 000, OutCSel = 00, OutDSel = 11 -> after 5 ns OutC = 1234, OutD = 5678.
- All registers = 1234, RegSel = 110, FunSel = 10, I = 3548, one clock, OutCSel = 10, OutDSel = 00 -> OutC = 1234 (SP unchanged), OutD = 3548 (PC loaded).
  - AR also = 3548 (check via OutDSel = 11).
- PC = FFFF, SP = 0000, RegSel = 100 with FunSel = 01, then RegSel = 001 with FunSel = 00:
  - Without the macro -> PC = 0000, SP = FFFF.
  - With ARF_SATURATE_EN -> PC = FFFF, SP = 0000.
- Registers nonzero, RegSel = 111, FunSel = 11, one clock -> all read 0000 on every select code.
- Mid-cycle, Reset low between edges with registers = ABCD -> OutC and OutD = 0000 immediately, before the next edge.
  - Then with Reset high, RegSel = 010, FunSel = 01, one clock -> AR = 0001, PC and SP = 0000.
- OutCSel = 01 vs 00 with PC = 55AA -> both give 55AA.
